// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a classic 5-stage in-order core.
// Holds the pipeline in flush for a few cycles after reset. It then resolves
// data-memory stalls, load-use hazards and taken branches into the PC, IF/ID,
// ID/EX and back-end control strobes. It also keeps saturating counts of
// stall and flush cycles.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             Branch_i,
    input  logic             MemStall_i,
    output logic             PCWrite_o,
    output logic             Stall_o,
    output logic             Flush_o,
    output logic             Bubble_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    // The boot counter is sized from BOOT_CYCLES alone. It keeps at least one
    // bit so that a zero-cycle boot still elaborates.
    localparam int BOOT_W = (BOOT_CYCLES >= 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST =
        BOOT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_MWAIT = 2'd2
    } state_t;

    state_t            state;
    logic [BOOT_W-1:0] boot_cnt;
    logic              in_boot;
    logic              load_use;

    // Decode the FSM state and the load-use hazard between EX and ID.
    always_comb begin
        in_boot  = (state == S_BOOT);
        // x0 is hard-wired to zero, so a load into x0 never creates a dependency.
        load_use = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                   ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
    end

    // Resolve the pipeline controls by priority: boot, memory stall, load-use, branch.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // branches below leaves a control unassigned and infers a latch.
        PCWrite_o = 1'b0;
        Stall_o   = 1'b0;
        Flush_o   = 1'b0;
        Bubble_o  = 1'b0;
        Freeze_o  = 1'b0;
        if (in_boot) begin
            Flush_o = 1'b1;
        end else if (MemStall_i) begin
            // Freeze follows MemStall_i directly, so it takes effect in the
            // same cycle the memory goes busy and does not wait for MWAIT.
            Freeze_o = 1'b1;
            Stall_o  = 1'b1;
        end else if (load_use) begin
            // The branch operands depend on the load, so a pending branch
            // waits for the bubble to clear.
            Stall_o  = 1'b1;
            Bubble_o = 1'b1;
        end else if (Branch_i) begin
            Flush_o   = 1'b1;
            PCWrite_o = 1'b1;
        end else begin
            PCWrite_o = 1'b1;
        end
    end

    // FSM: count out the boot period, then track the memory-wait episodes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_BOOT;
            boot_cnt <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments. Every
            // flop then samples pre-edge values, whatever the process order.
            case (state)
                S_BOOT: begin
                    boot_cnt <= boot_cnt + 1'b1;
                    if (boot_cnt == BOOT_LAST) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (MemStall_i) begin
                        state <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (!MemStall_i) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    // Performance counters: stall and flush cycles outside boot, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            StallCnt_o <= '0;
            FlushCnt_o <= '0;
        end else if (!in_boot) begin
            if (Stall_o && (StallCnt_o != '1)) begin
                StallCnt_o <= StallCnt_o + 1'b1;
            end
            if (Flush_o && (FlushCnt_o != '1)) begin
                FlushCnt_o <= FlushCnt_o + 1'b1;
            end
        end
    end

    // Stall and flush drive the same IF/ID register and are mutually exclusive after boot.
    a_no_stall_and_flush : assert property (
        @(posedge clk_i) disable iff (!rst_i)
        (state != S_BOOT) |-> !(Stall_o && Flush_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus for hazard_ctrl. A behavioural model
// predicts every output each cycle. Literal expectations at key points pin
// both the model and the DUT.
module tb_hazard_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             mr;
    logic [4:0]       rd, rs1, rs2;
    logic             br, ms;
    logic             PCWrite_o, Stall_o, Flush_o, Bubble_o, Freeze_o;
    logic [CNT_W-1:0] StallCnt_o, FlushCnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b1;

    always #5 clk = ~clk;

    hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .IDEX_MemRead_i(mr),
        .IDEX_Rd_i     (rd),
        .IFID_Rs1_i    (rs1),
        .IFID_Rs2_i    (rs2),
        .Branch_i      (br),
        .MemStall_i    (ms),
        .PCWrite_o     (PCWrite_o),
        .Stall_o       (Stall_o),
        .Flush_o       (Flush_o),
        .Bubble_o      (Bubble_o),
        .Freeze_o      (Freeze_o),
        .StallCnt_o    (StallCnt_o),
        .FlushCnt_o    (FlushCnt_o)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic pcw, stall, flush, bubble, freeze;
    } ctl_t;

    // The controls follow from a priority list of events.
    function automatic ctl_t rule(input bit booting, input logic m_rd_en,
                                  input logic [4:0] d, s1, s2,
                                  input logic b, m);
        ctl_t c;
        c = '0;
        if (booting)                                           c.flush = 1'b1;
        else if (m)                                            begin c.freeze = 1'b1; c.stall = 1'b1; end
        else if (m_rd_en && d != 0 && (d == s1 || d == s2))    begin c.stall = 1'b1;  c.bubble = 1'b1; end
        else if (b)                                            begin c.flush = 1'b1;  c.pcw = 1'b1; end
        else                                                   c.pcw = 1'b1;
        return c;
    endfunction

    int   m_boot_left;
    int   m_stall;
    int   m_flush;
    ctl_t exp_now;

    always_comb exp_now = rule(!rst_i || (m_boot_left > 0), mr, rd, rs1, rs2, br, ms);

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_boot_left <= BOOT_CYCLES;
            m_stall     <= 0;
            m_flush     <= 0;
        end else if (m_boot_left > 0) begin
            m_boot_left <= m_boot_left - 1;
        end else begin
            if (exp_now.stall) m_stall <= (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
            if (exp_now.flush) m_flush <= (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("m_pcwrite",   32'(PCWrite_o),  32'(exp_now.pcw));
            check("m_stall",     32'(Stall_o),    32'(exp_now.stall));
            check("m_flush",     32'(Flush_o),    32'(exp_now.flush));
            check("m_bubble",    32'(Bubble_o),   32'(exp_now.bubble));
            check("m_freeze",    32'(Freeze_o),   32'(exp_now.freeze));
            check("m_stall_cnt", 32'(StallCnt_o), 32'(m_stall));
            check("m_flush_cnt", 32'(FlushCnt_o), 32'(m_flush));
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic cyc(input logic a_mr, input logic [4:0] a_rd, a_rs1, a_rs2,
                       input logic a_br, input logic a_ms);
        @(posedge clk);
        #1;
        mr = a_mr; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; br = a_br; ms = a_ms;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic release_and_boot();
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("boot1_flush", 32'(Flush_o), 32'd1);
        check("boot1_pcw",   32'(PCWrite_o), 32'd0);
        idle();
        check("boot2_flush", 32'(Flush_o), 32'd1);
        idle();
        check("run_flush",   32'(Flush_o), 32'd0);
        check("run_pcw",     32'(PCWrite_o), 32'd1);
        check("run_scnt",    32'(StallCnt_o), 32'd0);
        check("run_fcnt",    32'(FlushCnt_o), 32'd0);
    endtask

    typedef struct {
        logic       a_mr;
        logic [4:0] a_rd, a_rs1, a_rs2;
        logic       a_br, a_ms;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst_i = 1'b0;
        mr = 1'b0; rd = '0; rs1 = '0; rs2 = '0; br = 1'b0; ms = 1'b0;

        // Reset held: boot controls and cleared counters.
        repeat (2) @(negedge clk);
        check("rst_flush", 32'(Flush_o), 32'd1);
        check("rst_pcw",   32'(PCWrite_o), 32'd0);
        check("rst_scnt",  32'(StallCnt_o), 32'd0);

        release_and_boot();

        // Load-use on rs2 beats a taken branch.
        cyc(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        check("lu_stall",  32'(Stall_o), 32'd1);
        check("lu_bubble", 32'(Bubble_o), 32'd1);
        check("lu_pcw",    32'(PCWrite_o), 32'd0);
        check("lu_flush",  32'(Flush_o), 32'd0);
        check("lu_scnt0",  32'(StallCnt_o), 32'd0);
        idle();
        check("lu_scnt1",  32'(StallCnt_o), 32'd1);

        // A load into x0 is no hazard, so the branch flushes.
        cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        check("x0_flush", 32'(Flush_o), 32'd1);
        check("x0_stall", 32'(Stall_o), 32'd0);
        idle();
        check("x0_fcnt",  32'(FlushCnt_o), 32'd1);

        // Load-use on rs1 (S=2), then a non-load with matching registers.
        cyc(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
        check("rs1_stall", 32'(Stall_o), 32'd1);
        cyc(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
        check("nold_pcw",  32'(PCWrite_o), 32'd1);

        // Memory stall for three cycles with a load-use pending, then the load-use stall.
        repeat (3) begin
            cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
            check("ms_freeze", 32'(Freeze_o), 32'd1);
            check("ms_stall",  32'(Stall_o), 32'd1);
            check("ms_bubble", 32'(Bubble_o), 32'd0);
        end
        cyc(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        check("mx_bubble", 32'(Bubble_o), 32'd1);
        check("mx_freeze", 32'(Freeze_o), 32'd0);
        check("mx_flush",  32'(Flush_o), 32'd0);
        idle();
        check("mx_scnt",   32'(StallCnt_o), 32'd6);

        // A branch on the MWAIT exit cycle flushes.
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        check("mxb_flush", 32'(Flush_o), 32'd1);
        idle();
        check("mxb_scnt",  32'(StallCnt_o), 32'd7);
        check("mxb_fcnt",  32'(FlushCnt_o), 32'd2);

        // Mixed vectors are checked by the model only.
        vecs[0] = '{1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd31, 5'd1, 5'd31, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 5'd4, 5'd2, 5'd2, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 5'd12, 5'd0, 5'd12, 1'b0, 1'b0};
        foreach (vecs[i]) cyc(vecs[i].a_mr, vecs[i].a_rd, vecs[i].a_rs1, vecs[i].a_rs2,
                              vecs[i].a_br, vecs[i].a_ms);

        // Reset pulled low in the middle of a memory wait acts without a clock edge.
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        check("ar_flush",  32'(Flush_o), 32'd1);
        check("ar_freeze", 32'(Freeze_o), 32'd0);
        check("ar_scnt",   32'(StallCnt_o), 32'd0);
        check("ar_fcnt",   32'(FlushCnt_o), 32'd0);
        ms = 1'b0;
        release_and_boot();

        // Saturation: 14 stall cycles reach all-ones-minus-1, and 3 more hold at all-ones.
        repeat (14) cyc(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
        check("sat_pre",  32'(StallCnt_o), 32'(CNT_MAX - 1));
        repeat (2) cyc(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
        check("sat_top",  32'(StallCnt_o), 32'(CNT_MAX));
        idle();
        check("sat_hold", 32'(StallCnt_o), 32'(CNT_MAX));
        repeat (18) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        check("fsat",     32'(FlushCnt_o), 32'(CNT_MAX));
        idle();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Upper bound on run time, in case the stimulus ever stops advancing.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
